// File: rtl/dm_pipe_pkg.sv
// Shared definitions for the MEM-stage data memory: access sizes, FSM states
// and the access-decoding helpers used by dm_pipe and dm_lane_ext.
package dm_pipe_pkg;

    localparam logic [1:0] DM_BYTE = 2'b00;
    localparam logic [1:0] DM_HALF = 2'b01;
    localparam logic [1:0] DM_WORD = 2'b10;

    typedef enum logic {
        DM_ST_CLEAR = 1'b0,
        DM_ST_RUN   = 1'b1
    } dm_state_e;

    // Misaligned half/word or the reserved size encoding.
    function automatic logic dm_bad_access(input logic [1:0] size, input logic [1:0] addr_lo);
        logic bad;
        case (size)
            DM_BYTE: bad = 1'b0;
            DM_HALF: bad = addr_lo[0];
            DM_WORD: bad = (addr_lo != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    function automatic logic [3:0] dm_byte_en(input logic [1:0] size, input logic [1:0] addr_lo);
        logic [3:0] be;
        case (size)
            DM_BYTE: be = 4'b0001 << addr_lo;
            DM_HALF: be = addr_lo[1] ? 4'b1100 : 4'b0011;
            DM_WORD: be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/dm_lane_ext.sv
// Little-endian lane selection and sign/zero extension of a 32-bit memory word.
// Purely combinational; shared with the cache fill path.
module dm_lane_ext
    import dm_pipe_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    output logic [31:0] result
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Pick the addressed lane, then extend it to 32 bits.
    always_comb begin
        case (addr_lo)
            2'b00:   byte_s = word[7:0];
            2'b01:   byte_s = word[15:8];
            2'b10:   byte_s = word[23:16];
            2'b11:   byte_s = word[31:24];
            default: byte_s = 8'h00;
        endcase
        half_s = addr_lo[1] ? word[31:16] : word[15:0];
        case (size)
            DM_BYTE: result = is_unsigned ? {24'h000000, byte_s} : {{24{byte_s[7]}}, byte_s};
            DM_HALF: result = is_unsigned ? {16'h0000, half_s} : {{16{half_s[15]}}, half_s};
            DM_WORD: result = word;
            default: result = 32'h00000000;
        endcase
    end

endmodule

// File: rtl/dm_pipe.sv
// Handshaked MEM-stage data memory with a single-entry response register.
// Build option: DM_CLEAR_ON_RESET_EN zero-fills the array after every reset.
module dm_pipe
    import dm_pipe_pkg::*;
#(
    parameter int DEPTH_WORDS = 256
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               req_valid,
    output logic                               req_ready,
    input  logic                               req_we,
    input  logic [1:0]                         req_size,
    input  logic                               req_unsigned,
    input  logic [$clog2(DEPTH_WORDS)+2-1:0]   req_addr,
    input  logic [31:0]                        req_wdata,
    output logic                               rsp_valid,
    input  logic                               rsp_ready,
    output logic [31:0]                        rsp_rdata,
    output logic                               rsp_err
);

    localparam int ADDR_W = $clog2(DEPTH_WORDS) + 2;
    localparam int IDX_W  = ADDR_W - 2;

    logic [31:0]      mem_r [DEPTH_WORDS];
    logic             rsp_valid_r;
    logic [31:0]      rsp_rdata_r;
    logic             rsp_err_r;
    logic             run_s;
    logic             clear_we_s;
    logic [IDX_W-1:0] clear_idx_s;
    logic             accept_s;
    logic             bad_s;
    logic             store_s;
    logic [3:0]       be_s;
    logic [31:0]      wlane_s;
    logic [31:0]      ext_s;
    logic [IDX_W-1:0] idx_s;

`ifdef DM_CLEAR_ON_RESET_EN
    dm_state_e        state_r;
    logic [IDX_W-1:0] clear_idx_r;

    // Clear sequencer: one word per cycle, then hand over to normal operation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= DM_ST_CLEAR;
            clear_idx_r <= '0;
        end else begin
            case (state_r)
                DM_ST_CLEAR: begin
                    clear_idx_r <= clear_idx_r + 1'b1;
                    if (clear_idx_r == IDX_W'(DEPTH_WORDS - 1)) begin
                        state_r <= DM_ST_RUN;
                    end else begin
                        state_r <= DM_ST_CLEAR;
                    end
                end
                DM_ST_RUN: state_r <= DM_ST_RUN;
                default:   state_r <= DM_ST_CLEAR;
            endcase
        end
    end

    assign run_s       = (state_r == DM_ST_RUN);
    assign clear_we_s  = (state_r == DM_ST_CLEAR) && !rst;
    assign clear_idx_s = clear_idx_r;
`else
    assign run_s       = 1'b1;
    assign clear_we_s  = 1'b0;
    assign clear_idx_s = '0;
`endif

    assign req_ready = !rst && run_s && (!rsp_valid_r || rsp_ready);
    assign accept_s  = req_valid && req_ready;
    assign idx_s     = req_addr[ADDR_W-1:2];
    assign bad_s     = dm_bad_access(req_size, req_addr[1:0]);
    assign store_s   = accept_s && req_we && !bad_s;
    assign be_s      = dm_byte_en(req_size, req_addr[1:0]);

    // Replicate narrow store data across lanes so the byte enables can pick it up.
    always_comb begin
        case (req_size)
            DM_BYTE: wlane_s = {4{req_wdata[7:0]}};
            DM_HALF: wlane_s = {2{req_wdata[15:0]}};
            default: wlane_s = req_wdata;
        endcase
    end

    dm_lane_ext u_lane_ext (
        .word        (mem_r[idx_s]),
        .addr_lo     (req_addr[1:0]),
        .size        (req_size),
        .is_unsigned (req_unsigned),
        .result      (ext_s)
    );

    // Storage array: clear writes take priority; stores update enabled lanes only.
    always_ff @(posedge clk) begin
        if (clear_we_s) begin
            mem_r[clear_idx_s] <= 32'h00000000;
        end else if (store_s) begin
            for (int k = 0; k < 4; k++) begin
                if (be_s[k]) begin
                    mem_r[idx_s][8*k +: 8] <= wlane_s[8*k +: 8];
                end
            end
        end
    end

    // Response register: loads on accept, holds until the consumer takes it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= 32'h00000000;
            rsp_err_r   <= 1'b0;
        end else if (accept_s) begin
            rsp_valid_r <= 1'b1;
            rsp_err_r   <= bad_s;
            rsp_rdata_r <= (req_we || bad_s) ? 32'h00000000 : ext_s;
        end else if (rsp_valid_r && rsp_ready) begin
            rsp_valid_r <= 1'b0;
        end
    end

    assign rsp_valid = rsp_valid_r;
    assign rsp_rdata = rsp_rdata_r;
    assign rsp_err   = rsp_err_r;

endmodule

// File: tb/tb_dm_pipe.sv
// Directed bench for dm_pipe: loads/stores, extension, alignment errors,
// backpressure and (with DM_CLEAR_ON_RESET_EN) the post-reset clear sequence.
module tb_dm_pipe;

    localparam int DEPTH = 16;
    localparam int AW    = $clog2(DEPTH) + 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_we = 1'b0;
    logic [1:0]    req_size = 2'b00;
    logic          req_unsigned = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [31:0]   req_wdata = 32'h00000000;
    logic          rsp_valid;
    logic          rsp_ready = 1'b1;
    logic [31:0]   rsp_rdata;
    logic          rsp_err;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    dm_pipe #(.DEPTH_WORDS(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    task automatic set_req(input logic we, input logic [1:0] sz, input logic uns,
                           input logic [AW-1:0] a, input logic [31:0] wd);
        req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
        req_addr = a; req_wdata = wd;
    endtask

    // Issue one request, wait for its accept, sample the response #1 after that edge.
    task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                          input logic [AW-1:0] a, input logic [31:0] wd,
                          output logic v, output logic [31:0] d, output logic e);
        int n = 0;
        set_req(we, sz, uns, a, wd);
        @(negedge clk);
        while (!req_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            checks++; fails++;
            $display("FAIL accept_timeout: req_ready=%0b required 1", req_ready);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        v = rsp_valid; d = rsp_rdata; e = rsp_err;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %0b want 0", rsp_valid); end
        checks++; if (rsp_rdata !== 32'h0) begin fails++; $display("FAIL reset_rdata: got %h want 0", rsp_rdata); end
        checks++; if (rsp_err !== 1'b0) begin fails++; $display("FAIL reset_err: got %0b want 0", rsp_err); end
        checks++; if (req_ready !== 1'b0) begin fails++; $display("FAIL reset_ready: got %0b want 0", req_ready); end
        @(negedge clk);
        rst = 1'b0;
`ifdef DM_CLEAR_ON_RESET_EN
        repeat (DEPTH + 1) @(posedge clk);
`else
        @(posedge clk);
`endif
        #1;
    endtask

    task automatic test_word;
        logic v, e; logic [31:0] d;
        do_req(1'b1, 2'b10, 1'b0, 6'd0, 32'h12345678, v, d, e);
        checks++; if (v !== 1'b1 || d !== 32'h0 || e !== 1'b0) begin fails++; $display("FAIL store_rsp: got v=%0b d=%h e=%0b want 1/0/0", v, d, e); end
        do_req(1'b0, 2'b10, 1'b0, 6'd0, 32'h0, v, d, e);
        checks++; if (v !== 1'b1) begin fails++; $display("FAIL load_latency: rsp_valid=%0b want 1", v); end
        checks++; if (d !== 32'h12345678 || e !== 1'b0) begin fails++; $display("FAIL load_word: got %h e=%0b want 12345678 e=0", d, e); end
    endtask

    task automatic test_sign_ext;
        logic v, e; logic [31:0] d;
        do_req(1'b0, 2'b00, 1'b0, 6'd0, 32'h0, v, d, e);
        checks++; if (d !== 32'h00000078) begin fails++; $display("FAIL lb_pos: got %h want 00000078", d); end
        do_req(1'b1, 2'b00, 1'b0, 6'd0, 32'hFFFFFF87, v, d, e);
        do_req(1'b0, 2'b00, 1'b0, 6'd0, 32'h0, v, d, e);
        checks++; if (d !== 32'hFFFFFF87) begin fails++; $display("FAIL lb_neg: got %h want ffffff87", d); end
        do_req(1'b0, 2'b00, 1'b1, 6'd0, 32'h0, v, d, e);
        checks++; if (d !== 32'h00000087) begin fails++; $display("FAIL lbu: got %h want 00000087", d); end
        do_req(1'b0, 2'b10, 1'b1, 6'd0, 32'h0, v, d, e);
        checks++; if (d !== 32'h12345687) begin fails++; $display("FAIL lw_after_sb: got %h want 12345687", d); end
        do_req(1'b0, 2'b01, 1'b0, 6'd2, 32'h0, v, d, e);
        checks++; if (d !== 32'h00001234) begin fails++; $display("FAIL lh_hi: got %h want 00001234", d); end
    endtask

    task automatic test_errors;
        logic v, e; logic [31:0] d;
        do_req(1'b0, 2'b01, 1'b0, 6'd1, 32'h0, v, d, e);
        checks++; if (e !== 1'b1 || d !== 32'h0) begin fails++; $display("FAIL mis_half: got e=%0b d=%h want 1/0", e, d); end
        do_req(1'b0, 2'b10, 1'b0, 6'd2, 32'h0, v, d, e);
        checks++; if (e !== 1'b1 || d !== 32'h0) begin fails++; $display("FAIL mis_word: got e=%0b d=%h want 1/0", e, d); end
        do_req(1'b0, 2'b11, 1'b0, 6'd0, 32'h0, v, d, e);
        checks++; if (e !== 1'b1 || d !== 32'h0) begin fails++; $display("FAIL rsv_size: got e=%0b d=%h want 1/0", e, d); end
        do_req(1'b1, 2'b10, 1'b0, 6'd1, 32'hAAAAAAAA, v, d, e);
        checks++; if (e !== 1'b1 || d !== 32'h0) begin fails++; $display("FAIL mis_store: got e=%0b d=%h want 1/0", e, d); end
        do_req(1'b1, 2'b11, 1'b0, 6'd0, 32'h55555555, v, d, e);
        do_req(1'b0, 2'b10, 1'b0, 6'd0, 32'h0, v, d, e);
        checks++; if (d !== 32'h12345687 || e !== 1'b0) begin fails++; $display("FAIL no_side_effect: got %h e=%0b want 12345687 e=0", d, e); end
    endtask

    task automatic test_back_to_back;
        logic v, e; logic [31:0] d;
        do_req(1'b1, 2'b10, 1'b0, 6'd4, 32'hDEADBEEF, v, d, e);
        set_req(1'b0, 2'b01, 1'b0, 6'd6, 32'h0);
        @(posedge clk); #1;
        checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hFFFFDEAD) begin fails++; $display("FAIL st_ld_fwd: got v=%0b %h want 1 ffffdead", rsp_valid, rsp_rdata); end
        set_req(1'b1, 2'b01, 1'b0, 6'd6, 32'h0000ABCD);
        @(posedge clk); #1;
        set_req(1'b0, 2'b10, 1'b0, 6'd4, 32'h0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        checks++; if (rsp_rdata !== 32'hABCDBEEF) begin fails++; $display("FAIL sh_lanes: got %h want abcdbeef", rsp_rdata); end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure;
        logic v, e; logic [31:0] d;
        rsp_ready = 1'b0;
        do_req(1'b0, 2'b10, 1'b0, 6'd0, 32'h0, v, d, e);
        set_req(1'b0, 2'b01, 1'b1, 6'd2, 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (req_ready !== 1'b0 || rsp_valid !== 1'b1 || rsp_rdata !== 32'h12345687) begin
                fails++;
                $display("FAIL hold_%0d: ready=%0b valid=%0b d=%h want 0/1/12345687", i, req_ready, rsp_valid, rsp_rdata);
            end
        end
        rsp_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 1'b1) begin fails++; $display("FAIL resume_ready: got %0b want 1", req_ready); end
        @(posedge clk); #1;
        checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h00001234) begin fails++; $display("FAIL b2b_0: got v=%0b %h want 1 00001234", rsp_valid, rsp_rdata); end
        set_req(1'b0, 2'b00, 1'b0, 6'd1, 32'h0);
        @(posedge clk); #1;
        checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h00000056) begin fails++; $display("FAIL b2b_1: got v=%0b %h want 1 00000056", rsp_valid, rsp_rdata); end
        set_req(1'b0, 2'b00, 1'b0, 6'd7, 32'h0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hFFFFFFAB) begin fails++; $display("FAIL b2b_2: got v=%0b %h want 1 ffffffab", rsp_valid, rsp_rdata); end
        @(posedge clk); #1;
        checks++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL drain: rsp_valid=%0b want 0", rsp_valid); end
    endtask

`ifdef DM_CLEAR_ON_RESET_EN
    task automatic count_clear(output int cnt);
        cnt = 0;
        while (!req_ready && cnt < 100) begin
            cnt++;
            @(negedge clk);
        end
    endtask

    task automatic test_clear;
        logic v, e; logic [31:0] d;
        int cnt;
        do_req(1'b1, 2'b10, 1'b0, 6'h3C, 32'hCAFEF00D, v, d, e);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        count_clear(cnt);
        checks++; if (cnt !== DEPTH) begin fails++; $display("FAIL clear_cycles: got %0d want %0d", cnt, DEPTH); end
        do_req(1'b0, 2'b10, 1'b0, 6'h3C, 32'h0, v, d, e);
        checks++; if (d !== 32'h0 || e !== 1'b0) begin fails++; $display("FAIL clear_data: got %h want 0", d); end
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        count_clear(cnt);
        checks++; if (cnt !== DEPTH) begin fails++; $display("FAIL clear_restart: got %0d want %0d", cnt, DEPTH); end
    endtask
`endif

    initial begin
        test_reset;
        test_word;
        test_sign_ext;
        test_errors;
        test_back_to_back;
        test_backpressure;
`ifdef DM_CLEAR_ON_RESET_EN
        test_clear;
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/dm_pipe.md
Name: dm_pipe

Overview:
Parametrised, handshaked data memory for the MIPS core's MEM stage. It supports byte, halfword and word loads and stores, both signed and unsigned loads, and little-endian lane selection. Reads are synchronous with one cycle of latency. A single-entry response register carries backpressure, and misaligned accesses are flagged instead of silently wrapping.

Parameters:
DEPTH_WORDS, 256, number of 32-bit words (default = 1 KiB); power of two, >= 4
ADDR_W, $clog2(DEPTH_WORDS)+2, byte-address width; derived localparam, not overridable

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  block can accept a request this cycle
req_we  in  1  1 = store, 0 = load
req_size  in  2  `DM_BYTE / `DM_HALF / `DM_WORD; 2'b11 reserved
req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend
req_addr  in  ADDR_W  byte address
req_wdata  in  32  store data; byte/half taken from the low bits
rsp_valid  out  1  response present
rsp_ready  in  1  consumer accepts the response
rsp_rdata  out  32  extended load data; 0 for stores and errors
rsp_err  out  1  misaligned or reserved-size access

Behaviour:
- Reset (async):
  - rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - FSM goes to CLEAR when DM_CLEAR_ON_RESET_EN is defined, otherwise to RUN.
  - req_ready=0 while rst is high.
- Handshakes:
  - A request is accepted on a cycle with req_valid && req_ready.
  - A response is consumed on a cycle with rsp_valid && rsp_ready.
- Ready rule: req_ready = (state==RUN) && (!rsp_valid || rsp_ready). Same-cycle consume plus accept sustains 1 request per cycle.
- Latency: a request accepted at edge N produces rsp_valid=1 after edge N, i.e. visible in cycle N+1.
- Every request, store or load, yields exactly one response. Responses stay in order.
- Response hold: while rsp_valid && !rsp_ready, rsp_rdata and rsp_err are held stable and no new request is accepted.
- Alignment:
  - Half requires addr[0]==0; word requires addr[1:0]==0.
  - Violation, or size 2'b11: no memory write; response has rsp_err=1, rsp_rdata=0.
- Store:
  - Writes byte lane(s) addr[1:0] at the accepting edge. Byte lane k holds bits 8k+7:8k (little-endian). Other lanes are unchanged.
  - Store response carries rdata=0, err=0.
- Load:
  - Word read from index addr[ADDR_W-1:2], lane-selected by addr[1:0], then extended to 32 bits per req_unsigned.
  - Word loads ignore req_unsigned.
- Ordering: a load accepted the cycle after a store to the same word returns the new data. Requests are serialised, so there is no hazard.
- Address wrap: not possible; ADDR_W exactly spans the memory.
- FSM states:
  - CLEAR: clear_idx counts 0..DEPTH_WORDS-1, writing 0 each cycle; req_ready=0. After writing the last index, go to RUN.
  - RUN: normal operation.
- Reset asserted during CLEAR restarts clearing from index 0.
- Reset asserted with rsp_valid=1 drops the pending response.

Optional Feature:
Macro DM_CLEAR_ON_RESET_EN.
- Defined: after reset the FSM spends exactly DEPTH_WORDS cycles in CLEAR, then enters RUN with every word reading 0.
- Undefined: the CLEAR state and counter are not built. RUN is entered on the first edge after reset release, and memory contents are undefined until written.

Decomposition:
- defines.v (shared):
  - `DM_BYTE=2'b00, `DM_HALF=2'b01, `DM_WORD=2'b10.
  - FSM state encodings DM_ST_CLEAR / DM_ST_RUN.
- Sub-module dm_lane_ext (combinational): inputs word, addr[1:0], size, unsigned; output extended 32-bit result. It is reused by the future cache fill path.
- dm_pipe holds the storage array, FSM, clear counter and response register.

Test Plan:
- Store word 0x12345678 at addr 0, then load word at addr 0 -> rsp_rdata=0x12345678, err=0, response one cycle after accept.
- Load signed byte at addr 0 -> 0x00000078. Then store byte 0x87 at addr 0, load signed byte -> 0xFFFFFF87, load unsigned byte -> 0x00000087, load word -> 0x12345687.
- Load half at addr 1, word at addr 2, and size 2'b11 at addr 0 -> each returns err=1, rdata=0. A word load at addr 0 afterwards still returns 0x12345687, proving no side effects.
- Backpressure: hold rsp_ready=0 for 3 cycles after a load response -> req_ready=0 and response stable. Raise rsp_ready with req_valid high -> back-to-back accepts resume at 1 per cycle.
- With DM_CLEAR_ON_RESET_EN and DEPTH_WORDS=16:
  - Pulse rst -> req_ready low for exactly 16 cycles, after which a word load at addr 0x3C returns 0.
  - Re-assert rst mid-clear at cycle 5 -> clearing restarts, and 16 more cycles elapse before ready.
